// File: rtl/executa_movimentos_if.sv
// Bus between the move executor, the move RAM read port and the face-motor drivers.
// The master side is the executor; the slave side is the RAM/driver environment.
interface executa_movimentos_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  iniciar;
    logic [2:0]            mem_dado;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [5:0]            motor_sel;
    logic                  step;
    logic                  ocupado;
    logic                  pronto;
    logic [2:0]            db_movimento;
    logic [3:0]            db_estado;

    modport master (
        input  iniciar, mem_dado,
        output mem_addr, motor_sel, step, ocupado, pronto, db_movimento, db_estado
    );

    modport slave (
        output iniciar, mem_dado,
        input  mem_addr, motor_sel, step, ocupado, pronto, db_movimento, db_estado
    );
endinterface

// File: rtl/executa_movimentos.sv
// Walks the move RAM from address 0, turning each move code into a one-hot motor
// select plus a step pulse train and a settle wait; pulses pronto when the list ends.
module executa_movimentos #(
    parameter int ADDR_WIDTH    = 5,
    parameter int STEPS_QUARTER = 50,
    parameter int HALF_PERIOD   = 25000,
    parameter int SETTLE_CYCLES = 500000
) (
    input  logic                 clock,
    input  logic                 reset,
    executa_movimentos_if.master bus
);
    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int PW = $clog2(STEPS_QUARTER + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [3:0] INICIAL     = 4'd0;
    localparam logic [3:0] LE          = 4'd1;
    localparam logic [3:0] DECODIFICA  = 4'd2;
    localparam logic [3:0] PASSO_ALTO  = 4'd3;
    localparam logic [3:0] PASSO_BAIXO = 4'd4;
    localparam logic [3:0] ESPERA      = 4'd5;
    localparam logic [3:0] PROXIMO     = 4'd6;
    localparam logic [3:0] FIM         = 4'd7;

    logic [3:0]            estado_r;
    logic [3:0]            estado_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [5:0]            motor_sel_r;
    logic                  step_r;
    logic                  ocupado_r;
    logic                  pronto_r;
    logic [2:0]            movimento_r;
    logic [HW-1:0]         meio_r;
    logic [PW-1:0]         passos_r;
    logic [SW-1:0]         espera_r;
    logic                  meio_fim_s;
    logic                  ultimo_passo_s;
    logic                  espera_fim_s;

    function automatic logic [5:0] onehot(input logic [2:0] code);
        onehot = 6'b000001 << code;
    endfunction

    assign meio_fim_s     = (meio_r == HW'(HALF_PERIOD - 1));
    assign ultimo_passo_s = (passos_r == PW'(STEPS_QUARTER - 1));
    assign espera_fim_s   = (espera_r == SW'(SETTLE_CYCLES - 1));

    // Next-state decision for the sequencing FSM.
    always_comb begin
        estado_s = estado_r;
        case (estado_r)
            INICIAL:     if (bus.iniciar) estado_s = LE; else estado_s = INICIAL;
            LE:          estado_s = DECODIFICA;
            DECODIFICA: begin
                if (bus.mem_dado == 3'b111)      estado_s = FIM;
                else if (bus.mem_dado == 3'b110) estado_s = PROXIMO;
                else                             estado_s = PASSO_ALTO;
            end
            PASSO_ALTO:  if (meio_fim_s) estado_s = PASSO_BAIXO; else estado_s = PASSO_ALTO;
            PASSO_BAIXO: begin
                if (!meio_fim_s)         estado_s = PASSO_BAIXO;
                else if (ultimo_passo_s) estado_s = ESPERA;
                else                     estado_s = PASSO_ALTO;
            end
            ESPERA:      if (espera_fim_s) estado_s = PROXIMO; else estado_s = ESPERA;
            PROXIMO:     if (&mem_addr_r) estado_s = FIM; else estado_s = LE;
            FIM:         estado_s = INICIAL;
            default:     estado_s = INICIAL;
        endcase
    end

    // State, counters and outputs; status outputs are registered from the next state
    // so they line up exactly with the state they describe.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_r    <= INICIAL;
            mem_addr_r  <= '0;
            motor_sel_r <= 6'b000000;
            step_r      <= 1'b0;
            ocupado_r   <= 1'b0;
            pronto_r    <= 1'b0;
            movimento_r <= 3'b000;
            meio_r      <= '0;
            passos_r    <= '0;
            espera_r    <= '0;
        end else begin
            estado_r  <= estado_s;
            ocupado_r <= (estado_s != INICIAL);
            step_r    <= (estado_s == PASSO_ALTO);
            pronto_r  <= (estado_s == FIM);

            if (estado_s == PROXIMO) begin
                motor_sel_r <= 6'b000000;
            end

            if ((estado_r == PASSO_ALTO) || (estado_r == PASSO_BAIXO)) begin
                meio_r <= meio_fim_s ? '0 : (meio_r + HW'(1));
            end else begin
                meio_r <= '0;
            end

            case (estado_r)
                INICIAL: begin
                    if (bus.iniciar) mem_addr_r <= '0;
                end
                DECODIFICA: begin
                    movimento_r <= bus.mem_dado;
                    if (bus.mem_dado < 3'b110) begin
                        motor_sel_r <= onehot(bus.mem_dado);
                        passos_r    <= '0;
                    end
                end
                PASSO_BAIXO: begin
                    if (meio_fim_s && (passos_r != PW'(STEPS_QUARTER))) begin
                        passos_r <= passos_r + PW'(1);
                    end
                end
                ESPERA: begin
                    espera_r <= espera_fim_s ? '0 : (espera_r + SW'(1));
                end
                PROXIMO: begin
                    if (!(&mem_addr_r)) mem_addr_r <= mem_addr_r + ADDR_WIDTH'(1);
                end
                default: begin
                    espera_r <= '0;
                end
            endcase
        end
    end

    assign bus.mem_addr     = mem_addr_r;
    assign bus.motor_sel    = motor_sel_r;
    assign bus.step         = step_r;
    assign bus.ocupado      = ocupado_r;
    assign bus.pronto       = pronto_r;
    assign bus.db_movimento = movimento_r;
    assign bus.db_estado    = estado_r;
endmodule

// File: tb/tb_executa_movimentos.sv
// Bench for executa_movimentos: builds the expected cycle-by-cycle trace of each run
// from the move list and compares every visible output against it.
module tb_executa_movimentos;
    localparam int AW = 3;
    localparam int SQ = 2;
    localparam int HP = 2;
    localparam int SC = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    executa_movimentos_if #(.ADDR_WIDTH(AW)) bus ();

    executa_movimentos #(
        .ADDR_WIDTH(AW), .STEPS_QUARTER(SQ), .HALF_PERIOD(HP), .SETTLE_CYCLES(SC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    logic [2:0] ram [0:7];

    // Synchronous-read move RAM: data valid one clock after the address.
    always @(posedge clock) bus.mem_dado <= ram[bus.mem_addr];

    typedef struct packed {
        logic [3:0] est;
        logic [2:0] addr;
        logic [5:0] motor;
        logic       step;
        logic       pronto;
        logic       ocup;
        logic [2:0] mov;
    } snap_t;

    snap_t      exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [2:0] model_mov = 3'b000;
    logic [2:0] model_addr = 3'b000;

    function automatic snap_t mk(logic [3:0] e, logic [2:0] a, logic [5:0] m,
                                 logic s, logic p, logic o, logic [2:0] mv);
        snap_t r;
        r = {e, a, m, s, p, o, mv};
        return r;
    endfunction

    function automatic snap_t observe();
        snap_t r;
        r = {bus.db_estado, bus.mem_addr, bus.motor_sel, bus.step, bus.pronto,
             bus.ocupado, bus.db_movimento};
        return r;
    endfunction

    // Expected trace of one run, one entry per clock, from the move-list rules.
    function automatic void build();
        logic [2:0] ad;
        logic [2:0] code;
        logic [5:0] oh;
        exp_q.delete();
        ad = 3'd0;
        for (int a = 0; a < 8; a++) begin
            ad = 3'(a);
            exp_q.push_back(mk(4'd1, ad, 6'd0, 1'b0, 1'b0, 1'b1, model_mov));
            exp_q.push_back(mk(4'd2, ad, 6'd0, 1'b0, 1'b0, 1'b1, model_mov));
            code = ram[a];
            model_mov = code;
            if (code == 3'b111) begin
                exp_q.push_back(mk(4'd7, ad, 6'd0, 1'b0, 1'b1, 1'b1, model_mov));
                break;
            end
            if (code != 3'b110) begin
                oh = 6'd0;
                oh[code] = 1'b1;
                for (int p = 0; p < SQ; p++) begin
                    for (int h = 0; h < HP; h++)
                        exp_q.push_back(mk(4'd3, ad, oh, 1'b1, 1'b0, 1'b1, model_mov));
                    for (int h = 0; h < HP; h++)
                        exp_q.push_back(mk(4'd4, ad, oh, 1'b0, 1'b0, 1'b1, model_mov));
                end
                for (int s = 0; s < SC; s++)
                    exp_q.push_back(mk(4'd5, ad, oh, 1'b0, 1'b0, 1'b1, model_mov));
            end
            exp_q.push_back(mk(4'd6, ad, 6'd0, 1'b0, 1'b0, 1'b1, model_mov));
            if (a == 7) begin
                exp_q.push_back(mk(4'd7, ad, 6'd0, 1'b0, 1'b1, 1'b1, model_mov));
                break;
            end
        end
        model_addr = ad;
        exp_q.push_back(mk(4'd0, model_addr, 6'd0, 1'b0, 1'b0, 1'b0, model_mov));
    endfunction

    task automatic check(input string tag, input snap_t o, input snap_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed est=%0d addr=%0d motor=%b step=%b pronto=%b ocup=%b mov=%b expected est=%0d addr=%0d motor=%b step=%b pronto=%b ocup=%b mov=%b",
                   tag, o.est, o.addr, o.motor, o.step, o.pronto, o.ocup, o.mov,
                   e.est, e.addr, e.motor, e.step, e.pronto, e.ocup, e.mov);
        end
    endtask

    // Start a run and check every clock until the FSM is back in INICIAL.
    task automatic run(input string tag, input bit hold, input bit noise);
        build();
        bus.iniciar = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clock); #1;
            check($sformatf("%s[%0d]", tag, i), observe(), exp_q[i]);
            if (i == exp_q.size() - 1) bus.iniciar = hold;
            else if (noise)            bus.iniciar = 1'($urandom);
            else                       bus.iniciar = hold;
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            check($sformatf("%s[%0d]", tag, i), observe(),
                  mk(4'd0, model_addr, 6'd0, 1'b0, 1'b0, 1'b0, model_mov));
        end
    endtask

    task automatic fill(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                        input logic [2:0] rest);
        ram[0] = c0;
        ram[1] = c1;
        ram[2] = c2;
        for (int i = 3; i < 8; i++) ram[i] = rest;
    endtask

    initial begin
        bus.iniciar = 1'b0;
        fill(3'b000, 3'b000, 3'b000, 3'b000);
        repeat (2) @(posedge clock);
        #1;
        check("reset", observe(), mk(4'd0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0, 3'd0));
        reset = 1'b1;
        idle("idle0", 2);

        fill(3'b010, 3'b111, 3'b011, 3'b001);
        run("face2_end", 1'b0, 1'b0);

        fill(3'b110, 3'b000, 3'b111, 3'b100);
        run("noop_face0", 1'b0, 1'b0);

        fill(3'b101, 3'b101, 3'b101, 3'b101);
        run("all101", 1'b0, 1'b0);
        idle("nowrap", 3);

        fill(3'b111, 3'b000, 3'b000, 3'b000);
        run("end_only", 1'b0, 1'b0);

        fill(3'b000, 3'b110, 3'b111, 3'b010);
        run("hold_a", 1'b1, 1'b0);
        run("hold_b", 1'b1, 1'b0);
        bus.iniciar = 1'b0;
        idle("hold_idle", 2);

        fill(3'b011, 3'b111, 3'b000, 3'b000);
        bus.iniciar = 1'b1;
        @(posedge clock); #1;
        bus.iniciar = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("pre_reset_alto", observe(),
              mk(4'd3, 3'd0, 6'b001000, 1'b1, 1'b0, 1'b1, 3'b011));
        reset = 1'b0;
        @(posedge clock); #1;
        check("mid_reset", observe(), mk(4'd0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0, 3'd0));
        reset = 1'b1;
        model_mov  = 3'b000;
        model_addr = 3'b000;
        idle("post_reset", 2);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin
                int pick;
                pick = $urandom_range(0, 9);
                if (pick < 6)       ram[i] = 3'(pick);
                else if (pick < 8)  ram[i] = 3'b110;
                else if (r == 5)    ram[i] = 3'b100;
                else                ram[i] = 3'b111;
            end
            run($sformatf("rand%0d", r), 1'b0, 1'b1);
        end
        bus.iniciar = 1'b0;
        idle("final_idle", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
